vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Raster timing generator directly upstream of the GPU text-mode core.
- Produces the pixel coordinates x[9:0]/y[8:0] consumed by the GPU core, plus monitor sync and blanking.
- hsync/vsync/blank are delayed by a configurable number of clk cycles so they line up with the GPU core's RGB output, which lags x/y by its VRAM → charset → color register pipeline.
- Default mode: 640x480@60, 25 MHz pixel rate derived from a 50 MHz clk.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel (≥1)
- SYNC_DELAY, 3, clk cycles of delay applied to hsync/vsync/blank (0..15)
- HSYNC_POL, 0, asserted level of hsync
- VSYNC_POL, 0, asserted level of vsync

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- x  out  10  pixel column to GPU core; 0 outside active region
- y  out  9  pixel row to GPU core; 0 outside active region
- pix_en  out  1  one-clk pulse each pixel step
- active  out  1  undelayed: current (x,y) is visible
- hsync  out  1  delayed horizontal sync to monitor
- vsync  out  1  delayed vertical sync to monitor
- blank  out  1  delayed inverse of active, for RGB gating
- frame_start  out  1  one-clk pulse when h=0, v=0 is entered

Behaviour:
- Reset (async on rst_n=0; outputs are registered):
  - div counter, h_cnt, v_cnt = 0; x = 0; y = 0; pix_en = 0; active = 0; frame_start = 0.
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL, blank = 1.
  - Delay line is filled with these deasserted values.
- Pixel enable:
  - div counter runs 0..CLK_DIV-1 and wraps; pix_en = 1 for the clk where div = CLK_DIV-1.
  - CLK_DIV = 1 → pix_en is constantly 1 after reset.
- Horizontal counter:
  - Internal h_cnt counts 0..H_TOTAL-1, where H_TOTAL = sum of H parameters (800 by default).
  - Advances only on pix_en and wraps to 0.
- Vertical counter:
  - Internal v_cnt (10 bits) counts 0..V_TOTAL-1 (525 by default).
  - Increments only on the pix_en that wraps h_cnt; wraps to 0 after V_TOTAL-1.
- Region decode (computed from the next-count values and registered, so outputs change in the same clk as the counters):
  - active = (h < H_ACTIVE) && (v < V_ACTIVE).
  - x = h[9:0] and y = v[8:0] when active, else 0.
  - hsync_raw asserted for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
  - vsync_raw asserted for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC; it spans whole lines, changing at h wrap.
- frame_start: one clk, coincident with the clk where h and v both become 0.
  - It does not fire on release from reset.
  - The first pulse comes after one full frame.
- Delay line:
  - SYNC_DELAY-stage shift register on {hsync_raw, vsync_raw, ~active}, shifted every clk (not gated by pix_en).
  - SYNC_DELAY = 0 → outputs directly from the registered raw values.
- Latency: x/y to hsync/vsync/blank is exactly SYNC_DELAY clks.
- Reset mid-frame: all state returns to reset values immediately; counting restarts from (0,0) on the first clk after deassertion.
- No simultaneous-event hazards: every counter has a single increment source.

Optional Feature:
- Macro VGA_TIMING_FRAME_CNT_EN.
- Defined:
  - Adds output port frame_cnt (out, 16), reset to 0, incremented on every frame_start, wrapping 0xFFFF → 0.
  - Adds output port vblank_irq (out, 1), a level set at the clk where v first reaches V_ACTIVE (h = 0) and cleared by frame_start.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
- Default params, release rst_n → pix_en toggles every 2 clks; x counts 0..639 in 1280 clks, then x = 0 and active = 0 for 320 clks; line period 1600 clks.
- Count hsync (SYNC_DELAY = 3): goes low at clk 1312+3 after line start, high again 192 clks later; 525 hsync pulses per frame.
- vsync low for exactly 2 lines (3200 clks), starting at line 490; frame period 840000 clks; frame_start pulses once per frame at (0,0).
- y = 479, x = 639 → next pixel x = 0, y = 0, active = 0 (line 480); blank rises 3 clks after active falls.
- Assert rst_n low mid-line (x = 300, y = 200) for 5 clks → all outputs at reset values within that clk; after release x = 0, y = 0 and the first frame_start comes after 840000 clks.
- With VGA_TIMING_FRAME_CNT_EN: frame_cnt reads 3 after 3 frames; vblank_irq is high from line 480 until the next frame_start; CLK_DIV = 1 run → line period 800 clks.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel coordinates for the text-mode GPU core, plus delayed sync/blank.
// Optional build macro VGA_TIMING_FRAME_CNT_EN adds the frame_cnt and vblank_irq outputs.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 2,
  parameter int SYNC_DELAY = 3,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       pix_en,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic       frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt,
  output logic        vblank_irq
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_S = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_E = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_S = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_E = 10'(V_ACTIVE + V_FP + V_SYNC);
  // Raw bundle is {hsync, vsync, blank}; idle is everything deasserted.
  localparam logic [2:0] RAW_IDLE = {~HSYNC_POL, ~VSYNC_POL, 1'b1};

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_en_q, pix_en_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic [9:0]       x_q, x_d;
  logic [8:0]       y_q, y_d;
  logic             active_q, active_d;
  logic             fs_q, fs_d;
  logic [2:0]       raw_q, raw_d;
  logic             h_wrap, v_wrap, hs_on, vs_on;

  always_comb begin
    div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    pix_en_d = (div_d == DIV_LAST);
    h_wrap   = (h_q == H_LAST);
    v_wrap   = (v_q == V_LAST);
    h_d      = h_q;
    v_d      = v_q;
    fs_d     = 1'b0;
    if (pix_en_q) begin
      h_d = h_wrap ? '0 : h_q + 1'b1;
      if (h_wrap) begin
        v_d  = v_wrap ? '0 : v_q + 1'b1;
        fs_d = v_wrap;
      end
    end
    // Decode from the next counts so region outputs move in the same clk as the counters.
    active_d = (h_d < H_ACT) && (v_d < V_ACT);
    x_d      = active_d ? h_d : '0;
    y_d      = active_d ? v_d[8:0] : '0;
    hs_on    = (h_d >= H_SYNC_S) && (h_d < H_SYNC_E);
    vs_on    = (v_d >= V_SYNC_S) && (v_d < V_SYNC_E);
    raw_d    = {hs_on ? HSYNC_POL : ~HSYNC_POL, vs_on ? VSYNC_POL : ~VSYNC_POL, ~active_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      pix_en_q <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      active_q <= 1'b0;
      fs_q     <= 1'b0;
      raw_q    <= RAW_IDLE;
    end else begin
      div_q    <= div_d;
      pix_en_q <= pix_en_d;
      h_q      <= h_d;
      v_q      <= v_d;
      x_q      <= x_d;
      y_q      <= y_d;
      active_q <= active_d;
      fs_q     <= fs_d;
      raw_q    <= raw_d;
    end
  end

  // Free-running shift (not pixel-gated) so the lag matches the GPU pipeline in clks.
  generate
    if (SYNC_DELAY == 0) begin : g_nodly
      assign {hsync, vsync, blank} = raw_q;
    end else begin : g_dly
      logic [2:0] dly_q [SYNC_DELAY];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < SYNC_DELAY; i++) dly_q[i] <= RAW_IDLE;
        end else begin
          dly_q[0] <= raw_q;
          for (int i = 1; i < SYNC_DELAY; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign {hsync, vsync, blank} = dly_q[SYNC_DELAY-1];
    end
  endgenerate

  assign x           = x_q;
  assign y           = y_q;
  assign pix_en      = pix_en_q;
  assign active      = active_q;
  assign frame_start = fs_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fcnt_q;
  logic        irq_q;
  logic        irq_set;

  assign irq_set = pix_en_q && h_wrap && (v_d == V_ACT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (fs_d) fcnt_q <= fcnt_q + 1'b1;
      if (irq_set) irq_q <= 1'b1;
      else if (fs_d) irq_q <= 1'b0;
    end
  end

  assign frame_cnt  = fcnt_q;
  assign vblank_irq = irq_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced 15x8 raster with directed, hand-computed vectors.
module tb_vga_timing_gen;

  logic       clk;
  logic       rst_n;
  logic [9:0] x_a, x_b;
  logic [8:0] y_a, y_b;
  logic       pe_a, act_a, hs_a, vs_a, bl_a, fs_a;
  logic       pe_b, act_b, hs_b, vs_b, bl_b, fs_b;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fc_a, fc_b;
  logic        irq_a, irq_b;
`endif

  // Instance a: CLK_DIV=2, SYNC_DELAY=3, vsync active-high. Line 30 clks, frame 240 clks.
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(2), .SYNC_DELAY(3), .HSYNC_POL(1'b0), .VSYNC_POL(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .x(x_a), .y(y_a), .pix_en(pe_a), .active(act_a),
    .hsync(hs_a), .vsync(vs_a), .blank(bl_a), .frame_start(fs_a)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc_a), .vblank_irq(irq_a)
`endif
  );

  // Instance b: CLK_DIV=1, no sync delay. Line 15 clks, frame 120 clks.
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(1), .SYNC_DELAY(0), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .x(x_b), .y(y_b), .pix_en(pe_b), .active(act_b),
    .hsync(hs_b), .vsync(vs_b), .blank(bl_b), .frame_start(fs_b)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc_b), .vblank_irq(irq_b)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [9:0] x;
    logic [8:0] y;
    logic       a, pe, hs, vs, bl, fs;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   k      = 0;
  int   phase  = 0;
  int   hs_low = 0;
  int   vs_hi  = 0;
  int   fs_cnt = 0;
  int   fs_b_cnt = 0;

  function automatic vec_t mk(int c, int xv, int yv, bit a, bit pe, bit hs, bit vs, bit bl, bit fs);
    vec_t v;
    v.cyc = c; v.x = 10'(xv); v.y = 9'(yv);
    v.a = a; v.pe = pe; v.hs = hs; v.vs = vs; v.bl = bl; v.fs = fs;
    return v;
  endfunction

  // scoreboard compare
  task automatic chk(input string nm, input int kk, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at k=%0d: got %0h expected %0h", nm, kk, got, exp);
    end
  endtask

  // One clk; sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    k++;
    if (phase == 0) begin
      if (k > 240 && k <= 480) begin
        if (hs_a == 1'b0) hs_low++;
        if (vs_a == 1'b1) vs_hi++;
      end
      if (fs_a) fs_cnt++;
`ifdef VGA_TIMING_FRAME_CNT_EN
      if (k == 119) chk("irq_before", k, irq_a, 0);
      if (k == 120) chk("irq_set", k, irq_a, 1);
      if (k == 239) chk("irq_hold", k, irq_a, 1);
      if (k == 240) chk("irq_clr", k, irq_a, 0);
      if (k == 480) chk("frame_cnt", k, fc_a, 2);
`endif
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x"}, k, x_a, 0);
    chk({tag, "_y"}, k, y_a, 0);
    chk({tag, "_pe"}, k, pe_a, 0);
    chk({tag, "_act"}, k, act_a, 0);
    chk({tag, "_hs"}, k, hs_a, 1);
    chk({tag, "_vs"}, k, vs_a, 0);
    chk({tag, "_bl"}, k, bl_a, 1);
    chk({tag, "_fs"}, k, fs_a, 0);
    chk({tag, "_b_hs"}, k, hs_b, 1);
    chk({tag, "_b_vs"}, k, vs_b, 1);
    chk({tag, "_b_bl"}, k, bl_b, 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk({tag, "_fc"}, k, fc_a, 0);
    chk({tag, "_irq"}, k, irq_a, 0);
`endif
  endtask

  initial begin
    //            cyc   x  y  a pe hs vs bl fs
    vecs.push_back(mk(0,   0, 0, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(1,   0, 0, 1, 1, 1, 0, 1, 0));
    vecs.push_back(mk(2,   1, 0, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(3,   1, 0, 1, 1, 1, 0, 1, 0));
    vecs.push_back(mk(4,   2, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(15,  7, 0, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(16,  0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(18,  0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(19,  0, 0, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(22,  0, 0, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(23,  0, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(28,  0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(29,  0, 0, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(30,  0, 1, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(33,  1, 1, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(104, 7, 3, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(120, 0, 0, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(152, 0, 0, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(153, 0, 0, 0, 1, 1, 1, 1, 0));
    vecs.push_back(mk(212, 0, 0, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk(213, 0, 0, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(239, 0, 0, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(240, 0, 0, 1, 0, 1, 0, 1, 1));
    vecs.push_back(mk(241, 0, 0, 1, 1, 1, 0, 1, 0));
    vecs.push_back(mk(243, 1, 0, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(480, 0, 0, 1, 0, 1, 0, 1, 1));

    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    k = 0;

    foreach (vecs[i]) begin
      while (k < vecs[i].cyc) step();
      chk("x", k, x_a, vecs[i].x);
      chk("y", k, y_a, vecs[i].y);
      chk("active", k, act_a, vecs[i].a);
      chk("pix_en", k, pe_a, vecs[i].pe);
      chk("hsync", k, hs_a, vecs[i].hs);
      chk("vsync", k, vs_a, vecs[i].vs);
      chk("blank", k, bl_a, vecs[i].bl);
      chk("frame_start", k, fs_a, vecs[i].fs);
    end
    chk("hs_low_clks", k, hs_low, 48);
    chk("vs_high_clks", k, vs_hi, 60);
    chk("fs_pulses", k, fs_cnt, 2);

    // Mid-line reset: move to x=2, pull rst_n low between edges.
    while (k < 484) step();
    chk("pre_rst_x", k, x_a, 2);
    phase = 1;
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    repeat (5) @(posedge clk);
    #1;
    chk_reset_vals("held");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    k = 0;
    fs_cnt = 0;
    chk("rel_x", k, x_a, 0);
    chk("rel_y", k, y_a, 0);
    chk("rel_fs", k, fs_a, 0);

    // After release: a's first frame_start exactly at 240; b run at CLK_DIV=1.
    for (int n = 1; n <= 240; n++) begin
      step();
      if (fs_a) fs_cnt++;
      if (fs_b) fs_b_cnt++;
      case (k)
        1: begin
          chk("b_pe", k, pe_b, 1); chk("b_act", k, act_b, 1); chk("b_x", k, x_b, 0);
        end
        8:   begin chk("b_x", k, x_b, 7); chk("b_bl", k, bl_b, 0); end
        9:   begin chk("b_act", k, act_b, 0); chk("b_bl", k, bl_b, 1); end
        10:  chk("b_hs", k, hs_b, 1);
        11:  chk("b_hs", k, hs_b, 0);
        13:  chk("b_hs", k, hs_b, 0);
        14:  chk("b_hs", k, hs_b, 1);
        16:  begin chk("b_y", k, y_b, 1); chk("b_x", k, x_b, 0); chk("b_act", k, act_b, 1); end
        20:  chk("b_pe", k, pe_b, 1);
        75:  chk("b_vs", k, vs_b, 1);
        76:  chk("b_vs", k, vs_b, 0);
        120: chk("b_fs", k, fs_b, 0);
        121: chk("b_fs", k, fs_b, 1);
        239: chk("a_fs_none_yet", k, fs_cnt, 0);
        240: chk("a_fs_first", k, fs_a, 1);
        default: ;
      endcase
    end
    chk("a_fs_count", k, fs_cnt, 1);
    chk("b_fs_count", k, fs_b_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
